// File: rtl/ps2_pkg.sv
// Shared constants, frame FSM state type and watchdog sizing helper for the
// PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // Watchdog limit in system clock cycles; integer MHz clocks assumed.
    function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                   input int unsigned timeout_us);
        return (clk_hz / 32'd1_000_000) * timeout_us;
    endfunction

endpackage

// File: rtl/ps2_key_rx_sync_filter.sv
// Brings the raw PS/2 pins into the system clock domain, debounces the PS/2
// clock and produces a one-cycle strobe on each accepted falling edge.
module ps2_sync_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILT = 8
) (
    input  logic clk_50m,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fe,
    output logic data_s
);

    localparam int unsigned CNT_W = (FILT > 1) ? $clog2(FILT) : 1;

    logic [1:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       data_sync_q, data_sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fclk_q, fclk_d;
    logic             fe_q, fe_d;

    // The counter tracks how many consecutive samples disagree with the
    // current filtered level; any agreeing sample restarts the run.
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        cnt_d       = '0;
        fclk_d      = fclk_q;
        fe_d        = 1'b0;
        if (clk_sync_q[1] != fclk_q) begin
            if (cnt_q == CNT_W'(FILT - 1)) begin
                fclk_d = clk_sync_q[1];
                fe_d   = fclk_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            cnt_q       <= '0;
            fclk_q      <= 1'b1;
            fe_q        <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            cnt_q       <= cnt_d;
            fclk_q      <= fclk_d;
            fe_q        <= fe_d;
        end
    end

    assign fe     = fe_q;
    assign data_s = data_sync_q[1];

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, checks parity and stop bit,
// drops release codes and presents one make code per key press.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TIMEOUT_US = 200,
    parameter int unsigned FILT       = 8
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keyCode,
    output logic       dataReady,
    output logic       extended,
    output logic       frameErr
);

    localparam int unsigned TO_CYC = timeout_cycles(CLK_HZ, TIMEOUT_US);
    localparam int unsigned WD_W   = $clog2(TO_CYC + 1);

    logic fe;
    logic data_s;

    ps2_sync_filter #(
        .FILT(FILT)
    ) u_sync_filter (
        .clk_50m (clk_50m),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .fe      (fe),
        .data_s  (data_s)
    );

    ps2_state_e      state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [7:0]      key_q, key_d;
    logic            ext_q, ext_d;
    logic            rdy_q, rdy_d;
    logic            err_q, err_d;
    logic            ext_pend_q, ext_pend_d;
    logic            brk_pend_q, brk_pend_d;
    logic            frame_ok;
    logic            frame_bad;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        wdog_d    = wdog_q;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fe && !data_s) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (fe) begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fe) begin
                    par_d   = data_s;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fe) begin
                    state_d = IDLE;
                    if (data_s && (^{shift_q, par_q})) begin
                        frame_ok = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // An edge in the limit cycle wins over the timeout.
        if (state_q == IDLE || fe) begin
            wdog_d = '0;
        end else if (wdog_q == WD_W'(TO_CYC)) begin
            wdog_d    = '0;
            state_d   = IDLE;
            frame_bad = 1'b1;
        end else begin
            wdog_d = wdog_q + WD_W'(1);
        end
    end

    // Byte decoder: prefixes are remembered until the next non-prefix byte.
    always_comb begin
        key_d      = key_q;
        ext_d      = ext_q;
        rdy_d      = 1'b0;
        err_d      = 1'b0;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        if (frame_bad) begin
            err_d      = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (frame_ok) begin
            if (shift_q == PS2_EXT) begin
                ext_pend_d = 1'b1;
            end else if (shift_q == PS2_BRK) begin
                brk_pend_d = 1'b1;
            end else if (brk_pend_q) begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end else begin
                key_d      = shift_q;
                ext_d      = ext_pend_q;
                rdy_d      = 1'b1;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            wdog_q     <= '0;
            key_q      <= '0;
            ext_q      <= 1'b0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            wdog_q     <= wdog_d;
            key_q      <= key_d;
            ext_q      <= ext_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
        end
    end

    assign keyCode   = key_q;
    assign extended  = ext_q;
    assign dataReady = rdy_q;
    assign frameErr  = err_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Randomised PS/2 frame stimulus scored against an event-level model of the
// receiver, plus a few literal output expectations.
module tb_ps2_key_rx;

    localparam int unsigned CLK_HZ     = 1_000_000;
    localparam int unsigned TIMEOUT_US = 200;
    localparam int unsigned FILT       = 8;
    localparam int          LIMIT      = CLK_HZ / 1_000_000 * TIMEOUT_US;

    logic       clk_50m  = 1'b0;
    logic       rst      = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keyCode;
    logic       dataReady;
    logic       extended;
    logic       frameErr;

    ps2_key_rx #(
        .CLK_HZ    (CLK_HZ),
        .TIMEOUT_US(TIMEOUT_US),
        .FILT      (FILT)
    ) dut (
        .clk_50m  (clk_50m),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .keyCode  (keyCode),
        .dataReady(dataReady),
        .extended (extended),
        .frameErr (frameErr)
    );

    always #5 clk_50m = ~clk_50m;

    int cyc = 0;
    always @(posedge clk_50m) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] key;
        bit         ext;
        int         lo;
        int         hi;
    } ev_t;

    ev_t        evq[$];
    ev_t        cur;
    int         n_chk   = 0;
    int         n_fail  = 0;
    logic [7:0] exp_key = 8'h00;
    bit         exp_ext = 1'b0;

    // model prefix state, owned by the stimulus process
    bit m_ext_pend = 1'b0;
    bit m_brk_pend = 1'b0;

    int         pin_seq  = 0;
    int         pin_done = 0;
    logic [7:0] pin_key  = 8'h00;
    bit         pin_ext  = 1'b0;
    string      pin_name = "";

    // Compare process: every cycle, strobes against expected events and the
    // held outputs against the last expected make code.
    initial begin
        forever begin
            @(negedge clk_50m);
            if (!rst) begin
                exp_key = 8'h00;
                exp_ext = 1'b0;
                evq.delete();
            end else begin
                n_chk++;
                if (dataReady && frameErr) begin
                    n_fail++;
                    $display("FAIL strobe_excl: cyc %0d dataReady=1 frameErr=1, required not both", cyc);
                end
                if (dataReady || frameErr) begin
                    n_chk++;
                    if (evq.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_strobe: cyc %0d dataReady=%0b frameErr=%0b keyCode=%h, required no strobe",
                                 cyc, dataReady, frameErr, keyCode);
                    end else begin
                        cur = evq.pop_front();
                        if (cur.is_err != frameErr || cyc < cur.lo || cyc > cur.hi ||
                            (!cur.is_err && (keyCode !== cur.key || extended !== cur.ext))) begin
                            n_fail++;
                            $display("FAIL strobe_event: cyc %0d frameErr=%0b keyCode=%h extended=%0b, required frameErr=%0b keyCode=%h extended=%0b in cycles %0d..%0d",
                                     cyc, frameErr, keyCode, extended, cur.is_err, cur.key, cur.ext, cur.lo, cur.hi);
                        end
                        if (!cur.is_err) begin
                            exp_key = cur.key;
                            exp_ext = cur.ext;
                        end
                    end
                end else if (evq.size() > 0 && cyc > evq[0].hi) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL missed_strobe: cyc %0d no strobe, required %s by cycle %0d",
                             cyc, evq[0].is_err ? "frameErr" : "dataReady", evq[0].hi);
                    cur = evq.pop_front();
                end
                n_chk++;
                if (keyCode !== exp_key || extended !== exp_ext) begin
                    n_fail++;
                    $display("FAIL held_outputs: cyc %0d keyCode=%h extended=%0b, required keyCode=%h extended=%0b",
                             cyc, keyCode, extended, exp_key, exp_ext);
                end
            end
            if (pin_seq != pin_done) begin
                pin_done = pin_seq;
                n_chk++;
                if (keyCode !== pin_key || extended !== pin_ext || dataReady !== 1'b0 || frameErr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pin_%s: keyCode=%h extended=%0b dataReady=%0b frameErr=%0b, required keyCode=%h extended=%0b dataReady=0 frameErr=0",
                             pin_name, keyCode, extended, dataReady, frameErr, pin_key, pin_ext);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic pin(input string nm, input logic [7:0] k, input bit e);
        pin_name = nm;
        pin_key  = k;
        pin_ext  = e;
        pin_seq++;
        idle(2);
    endtask

    task automatic clk_fall(input bit b, input int half);
        ps2_data = b;
        idle(half);
        ps2_clk = 1'b0;
    endtask

    task automatic clk_rise(input int half);
        idle(half);
        ps2_clk = 1'b1;
    endtask

    task automatic push_ev(input bit is_err, input logic [7:0] key, input bit ext,
                           input int lo, input int hi);
        ev_t e;
        e.is_err = is_err;
        e.key    = key;
        e.ext    = ext;
        e.lo     = lo;
        e.hi     = hi;
        evq.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int half);
        logic [10:0] bits;
        bit          par;
        par  = ~(^b) ^ bad_par;
        bits = {~bad_stop, par, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            clk_fall(bits[i], half);
            clk_rise(half);
        end
        clk_fall(bits[10], half);
        if (bad_par || bad_stop) begin
            push_ev(1'b1, 8'h00, 1'b0, cyc + 10, cyc + 12);
            m_ext_pend = 1'b0;
            m_brk_pend = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext_pend = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk_pend = 1'b1;
        end else if (m_brk_pend) begin
            m_ext_pend = 1'b0;
            m_brk_pend = 1'b0;
        end else begin
            push_ev(1'b0, b, m_ext_pend, cyc + 10, cyc + 12);
            m_ext_pend = 1'b0;
            m_brk_pend = 1'b0;
        end
        clk_rise(half);
        ps2_data = 1'b1;
        idle(10);
    endtask

    // Start bit plus nbits data bits, then the line goes quiet.
    task automatic send_stalled(input int nbits, input int half);
        for (int i = 0; i <= nbits; i++) begin
            clk_fall((i == 0) ? 1'b0 : 1'($urandom_range(0, 1)), half);
            if (i == nbits) begin
                push_ev(1'b1, 8'h00, 1'b0, cyc + LIMIT + 8, cyc + LIMIT + 16);
            end
            clk_rise(half);
        end
        ps2_data   = 1'b1;
        m_ext_pend = 1'b0;
        m_brk_pend = 1'b0;
        idle(LIMIT + 60);
    endtask

    initial begin
        int          r;
        logic [7:0]  b;
        idle(3);
        pin("reset_state", 8'h00, 1'b0);
        rst = 1'b1;
        idle(20);

        send_frame(8'h1C, 1'b0, 1'b0, 20);
        pin("make_1c", 8'h1C, 1'b0);

        send_frame(8'hF0, 1'b0, 1'b0, 20);
        send_frame(8'h1C, 1'b0, 1'b0, 20);
        pin("release_hold", 8'h1C, 1'b0);
        send_frame(8'h32, 1'b0, 1'b0, 20);
        pin("after_release", 8'h32, 1'b0);

        send_frame(8'hE0, 1'b0, 1'b0, 20);
        send_frame(8'h75, 1'b0, 1'b0, 20);
        pin("ext_75", 8'h75, 1'b1);
        send_frame(8'h29, 1'b0, 1'b0, 20);
        pin("ext_clear", 8'h29, 1'b0);

        send_frame(8'h5A, 1'b1, 1'b0, 20);
        pin("bad_parity_hold", 8'h29, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 20);
        pin("good_5a", 8'h5A, 1'b0);

        send_stalled(4, 20);
        send_frame(8'h1B, 1'b0, 1'b0, 20);
        pin("after_timeout", 8'h1B, 1'b0);

        // short low pulse with data low: a false edge would start a frame
        ps2_data = 1'b0;
        idle(5);
        ps2_clk = 1'b0;
        idle(3);
        ps2_clk = 1'b1;
        idle(5);
        ps2_data = 1'b1;
        idle(LIMIT + 60);
        pin("glitch_ignored", 8'h1B, 1'b0);

        // reset in the middle of a frame
        for (int i = 0; i < 4; i++) begin
            clk_fall((i == 0) ? 1'b0 : 1'b1, 20);
            clk_rise(20);
        end
        rst = 1'b0;
        m_ext_pend = 1'b0;
        m_brk_pend = 1'b0;
        idle(2);
        pin("mid_frame_reset", 8'h00, 1'b0);
        ps2_data = 1'b1;
        rst = 1'b1;
        idle(20);
        send_frame(8'h23, 1'b0, 1'b0, 20);
        pin("after_reset", 8'h23, 1'b0);

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 11));
            if (r == 0) begin
                send_stalled(int'($urandom_range(0, 9)), int'($urandom_range(14, 30)));
            end else begin
                if (r <= 2)      b = 8'hE0;
                else if (r <= 4) b = 8'hF0;
                else             b = 8'($urandom_range(0, 255));
                send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                           int'($urandom_range(14, 30)));
            end
        end
        idle(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
